key_debouncer: RTL and testbench
================================

Name: key_debouncer

Overview:
- Input-side conditioning for the board push-buttons and slide switches. The top level reads these raw and active-low today.
- Per key:
  - synchronises the raw asynchronous active-low level;
  - filters bounce with a stability counter;
  - presents a clean active-high level plus one-cycle press, release and auto-repeat pulses.
- Sits directly behind the key pins; downstream lab logic consumes the clean outputs instead of raw key bits.

Parameters:
- N_KEYS, 2, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Minimum 2.
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat pulse (0.5 s). 0 disables auto-repeat.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (0.1 s). Minimum 1.

Ports:
- clk  input  1  system clock (max10_clk1_50 at top).
- reset  input  1  synchronous, active-high reset.
- key_n  input  N_KEYS  raw asynchronous key levels, active-low (0 = pressed).
- pressed  output  N_KEYS  debounced level, active-high.
- press_pulse  output  N_KEYS  one-cycle strobe on accepted press.
- release_pulse  output  N_KEYS  one-cycle strobe on accepted release.
- repeat_pulse  output  N_KEYS  one-cycle strobe while held, per auto-repeat timing.
- any_pressed  output  1  OR-reduction of pressed.

Behaviour:
- One clock domain. Reset is synchronous and active-high; it applies on the clk edge where reset=1.
- Reset values:
  - pressed = 0, all pulses = 0, any_pressed = 0.
  - Synchroniser flops = 1 (released); all counters = 0; every channel state = UP.
- Synchroniser: 2 flops per key, s1 <= key_n, s2 <= s1. Logic uses raw_pressed = ~s2.
- Per-channel FSM, states UP and DOWN; pressed = (state == DOWN).
  - Stability counter db_cnt, width clog2(DEBOUNCE_CYCLES).
  - Each cycle, if raw_pressed == pressed: db_cnt <= 0.
  - Otherwise, if db_cnt == DEBOUNCE_CYCLES-1: state toggles and db_cnt <= 0.
  - Otherwise: db_cnt increments.
  - Any single-cycle return to the current level clears db_cnt; a glitch shorter than DEBOUNCE_CYCLES never changes pressed.
- Latency: let edge 1 be the first edge that samples key_n low, held stable thereafter. pressed rises on edge DEBOUNCE_CYCLES+2. Release uses identical latency.
- press_pulse / release_pulse:
  - Registered, high exactly for the single cycle after the edge on which state changes to DOWN / UP.
  - Coincident with the first cycle of the new pressed level.
- Auto-repeat (REPEAT_DELAY > 0):
  - rpt_cnt clears on entry to DOWN and counts while in DOWN.
  - When rpt_cnt reaches REPEAT_DELAY-1: repeat_pulse for one cycle, then rpt_cnt reloads to phase REPEAT_PERIOD.
  - Thereafter one pulse every REPEAT_PERIOD cycles while DOWN.
  - Leaving DOWN clears rpt_cnt in the same cycle; no repeat_pulse can coincide with release_pulse.
  - repeat_pulse never coincides with press_pulse.
- REPEAT_DELAY = 0: repeat_pulse tied 0; rpt_cnt logic removed.
- Channels are fully independent. Simultaneous presses on several keys yield simultaneous pulses.
- any_pressed is a registered OR of state bits, the same cycle as pressed.
- Reset mid-operation (mid-count or held key):
  - All state returns to UP with no release_pulse emitted.
  - A key still held after reset deasserts re-qualifies with full latency, DEBOUNCE_CYCLES+2 edges from the first post-reset edge.
- Counters saturate-free by construction: db_cnt never exceeds DEBOUNCE_CYCLES-1, rpt_cnt never exceeds max(REPEAT_DELAY, REPEAT_PERIOD)-1.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_KEYS=2.
- Clean press: key_n[0] 1→0 held -> pressed[0] rises on edge 6; press_pulse[0] high for exactly 1 cycle; key 1 outputs stay 0.
- Bounce: key_n[0] low 3 cycles, high 1, low 3, high -> pressed[0] stays 0; no pulses.
- Bounce then settle: key_n[0] low 2, high 1, then low held -> pressed rises 6 edges after the final falling sample; exactly one press_pulse.
- Release: from DOWN, key_n[0] 0→1 held -> pressed falls on edge 6; one release_pulse; no repeat_pulse that cycle.
- Auto-repeat: hold 30 cycles after acceptance -> repeat_pulse at 10, 13, 16, 19, 22, 25, 28 cycles after press_pulse; none after release.
- Reset while held: assert reset 1 cycle while pressed[0]=1 -> next cycle all outputs 0, no release_pulse; key still low -> pressed re-rises 6 edges later with a fresh press_pulse. Both keys pressed same cycle -> identical simultaneous pulses; any_pressed=1.

Source files
------------

// File: rtl/key_debouncer.sv
// Per-key push-button conditioning: two-flop synchroniser, stability-count debounce,
// clean active-high level with press/release strobes and optional auto-repeat strobes.
module key_debouncer #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic              any_pressed
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } state_t;

    logic [N_KEYS-1:0] s1_q;
    logic [N_KEYS-1:0] s2_q;
    logic [N_KEYS-1:0] down_d;
    logic              any_pressed_q;

    // Synchronisers reset to the released (high) level so no false press follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q          <= '1;
            s2_q          <= '1;
            any_pressed_q <= 1'b0;
        end else begin
            s1_q          <= key_n;
            s2_q          <= s1_q;
            any_pressed_q <= |down_d;
        end
    end

    assign any_pressed = any_pressed_q;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        state_t          state_q;
        state_t          state_d;
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic            press_q;
        logic            press_d;
        logic            release_q;
        logic            release_d;
        logic            raw_pressed;
        logic            flip;

        always_comb begin
            raw_pressed = ~s2_q[g];
            flip        = 1'b0;
            state_d     = state_q;
            db_cnt_d    = db_cnt_q;
            if (raw_pressed == (state_q == DOWN)) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                flip     = 1'b1;
                db_cnt_d = '0;
                state_d  = (state_q == DOWN) ? UP : DOWN;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
            press_d   = flip && (state_q == UP);
            release_d = flip && (state_q == DOWN);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= UP;
                db_cnt_q  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                db_cnt_q  <= db_cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign down_d[g]        = (state_d == DOWN);
        assign pressed[g]       = (state_q == DOWN);
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;

        if (REPEAT_DELAY > 0) begin : g_rpt
            localparam logic [RPT_W-1:0] FIRST_LAST = RPT_W'(REPEAT_DELAY - 1);
            localparam logic [RPT_W-1:0] NEXT_LAST  = RPT_W'(REPEAT_PERIOD - 1);

            logic [RPT_W-1:0] rpt_cnt_q;
            logic [RPT_W-1:0] rpt_cnt_d;
            logic             periodic_q;
            logic             periodic_d;
            logic             repeat_q;
            logic             repeat_d;

            // The counter is held clear outside DOWN and on the leaving edge, so a
            // repeat strobe can never land on the same cycle as press or release.
            always_comb begin
                rpt_cnt_d  = rpt_cnt_q;
                periodic_d = periodic_q;
                repeat_d   = 1'b0;
                if ((state_q != DOWN) || flip) begin
                    rpt_cnt_d  = '0;
                    periodic_d = 1'b0;
                end else if (rpt_cnt_q == (periodic_q ? NEXT_LAST : FIRST_LAST)) begin
                    repeat_d   = 1'b1;
                    rpt_cnt_d  = '0;
                    periodic_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rpt_cnt_q  <= '0;
                    periodic_q <= 1'b0;
                    repeat_q   <= 1'b0;
                end else begin
                    rpt_cnt_q  <= rpt_cnt_d;
                    periodic_q <= periodic_d;
                    repeat_q   <= repeat_d;
                end
            end

            assign repeat_pulse[g] = repeat_q;
        end else begin : g_no_rpt
            assign repeat_pulse[g] = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios then random key activity, every cycle
// compared against a sliding-window / elapsed-time reference model.
module tb_key_debouncer;

    localparam int N_KEYS = 2;
    localparam int DB     = 4;
    localparam int RD     = 10;
    localparam int RP     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] pressed;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] repeat_pulse;
    logic              any_pressed;

    always #5 clk = ~clk;

    key_debouncer #(
        .N_KEYS         (N_KEYS),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n        (key_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .any_pressed  (any_pressed)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: pin-delay line, window of the last DB synchronised samples,
    // debounced level and elapsed cycles since acceptance.
    bit                m_s1   [N_KEYS];
    bit                m_s2   [N_KEYS];
    bit                m_hist [N_KEYS][DB];
    bit                m_state[N_KEYS];
    int                m_k    [N_KEYS];
    logic [N_KEYS-1:0] m_pressed, m_press, m_rel, m_rep;
    logic              m_any;

    int cnt_press[N_KEYS];
    int cnt_rel  [N_KEYS];
    int cnt_rep  [N_KEYS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit all_diff;
        if (reset) begin
            for (int k = 0; k < N_KEYS; k++) begin
                m_s1[k]    = 1'b1;
                m_s2[k]    = 1'b1;
                for (int j = 0; j < DB; j++) m_hist[k][j] = 1'b0;
                m_state[k] = 1'b0;
                m_k[k]     = 0;
            end
            m_press = '0;
            m_rel   = '0;
            m_rep   = '0;
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                for (int j = DB - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                m_hist[k][0] = ~m_s2[k];
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++) if (m_hist[k][j] == m_state[k]) all_diff = 1'b0;
                m_press[k] = all_diff && !m_state[k];
                m_rel[k]   = all_diff && m_state[k];
                m_rep[k]   = 1'b0;
                if (m_state[k] && !all_diff) begin
                    m_k[k]++;
                    if (RD > 0 && m_k[k] >= RD && ((m_k[k] - RD) % RP) == 0) m_rep[k] = 1'b1;
                end else begin
                    m_k[k] = 0;
                end
                if (all_diff) m_state[k] = !m_state[k];
                m_s2[k] = m_s1[k];
                m_s1[k] = key_n[k];
            end
        end
        for (int k = 0; k < N_KEYS; k++) m_pressed[k] = m_state[k];
        m_any = |m_pressed;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("pressed", pressed, m_pressed);
        check_eq("press_pulse", press_pulse, m_press);
        check_eq("release_pulse", release_pulse, m_rel);
        check_eq("repeat_pulse", repeat_pulse, m_rep);
        check_eq("any_pressed", any_pressed, m_any);
        for (int k = 0; k < N_KEYS; k++) begin
            cnt_press[k] += press_pulse[k];
            cnt_rel[k]   += release_pulse[k];
            cnt_rep[k]   += repeat_pulse[k];
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < N_KEYS; k++) begin
            cnt_press[k] = 0;
            cnt_rel[k]   = 0;
            cnt_rep[k]   = 0;
        end
    endtask

    task automatic wait_level(input int key, input logic lvl, output int edges);
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pressed[key] === lvl) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int first_off;
        int last_off;
        int seg[N_KEYS];

        reset = 1'b1;
        key_n = 2'b11;
        clear_counts();
        tick();
        tick();
        check_eq("rst_pressed", pressed, 0);
        check_eq("rst_any", any_pressed, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Clean press and auto-repeat on key 0.
        clear_counts();
        key_n = 2'b10;
        wait_level(0, 1'b1, e);
        check_eq("clean_latency", e, 6);
        check_eq("clean_press_pulse", press_pulse[0], 1);
        check_eq("clean_key1", pressed[1], 0);
        clear_counts();
        first_off = -1;
        last_off  = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (repeat_pulse[0]) begin
                if (first_off < 0) first_off = i;
                last_off = i;
            end
        end
        check_eq("clean_press_count", cnt_press[0], 0);
        check_eq("repeat_count", cnt_rep[0], 7);
        check_eq("repeat_first", first_off, 10);
        check_eq("repeat_last", last_off, 28);

        // Release.
        key_n = 2'b11;
        clear_counts();
        wait_level(0, 1'b0, e);
        check_eq("release_latency", e, 6);
        check_eq("release_pulse_now", release_pulse[0], 1);
        check_eq("rel_no_repeat", repeat_pulse[0], 0);
        clear_counts();
        for (int i = 0; i < 12; i++) tick();
        check_eq("after_rel_repeats", cnt_rep[0], 0);
        check_eq("after_rel_releases", cnt_rel[0], 0);

        // Bounce that never qualifies.
        clear_counts();
        key_n = 2'b10; for (int i = 0; i < 3; i++) tick();
        key_n = 2'b11; tick();
        key_n = 2'b10; for (int i = 0; i < 3; i++) tick();
        key_n = 2'b11; for (int i = 0; i < 10; i++) tick();
        check_eq("bounce_press_count", cnt_press[0], 0);
        check_eq("bounce_pressed", pressed[0], 0);

        // Bounce then settle.
        clear_counts();
        key_n = 2'b10; for (int i = 0; i < 2; i++) tick();
        key_n = 2'b11; tick();
        key_n = 2'b10;
        wait_level(0, 1'b1, e);
        check_eq("settle_latency", e, 6);
        for (int i = 0; i < 4; i++) tick();
        check_eq("settle_press_count", cnt_press[0], 1);

        // Reset while held, then re-qualification.
        clear_counts();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_held_pressed", pressed, 0);
        check_eq("rst_held_release", release_pulse, 0);
        wait_level(0, 1'b1, e);
        check_eq("rst_requal_latency", e, 6);
        check_eq("rst_requal_press", press_pulse[0], 1);
        check_eq("rst_no_release", cnt_rel[0], 0);

        // Simultaneous press on both keys.
        key_n = 2'b11;
        for (int i = 0; i < 10; i++) tick();
        key_n = 2'b00;
        wait_level(0, 1'b1, e);
        check_eq("both_latency", e, 6);
        check_eq("both_press", press_pulse, 2'b11);
        check_eq("both_any", any_pressed, 1);
        key_n = 2'b11;
        for (int i = 0; i < 10; i++) tick();

        // Random activity with occasional resets.
        for (int k = 0; k < N_KEYS; k++) seg[k] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N_KEYS; k++) begin
                seg[k]--;
                if (seg[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    seg[k] = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 5)
                                                        : $urandom_range(4, 45);
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
